// File: rtl/exp_block_16_pkg.sv
// exp_block_16_pkg: shared constants, FSM states and the 2^-f table generator for exp_block_16
package exp_block_16_pkg;
  localparam int LUT_DEPTH = 256;
  localparam logic [15:0] LOG2E_Q15 = 16'hB8AA;
  localparam logic [15:0] ONE_Q16 = 16'hFFFF;
  typedef enum logic [1:0] {IDLE, MUL, LUT, SHIFT} state_t;
  function automatic logic [63:0] q62_mul(input logic [63:0] a, input logic [63:0] b);
    logic [127:0] p;
    p = {64'd0, a} * {64'd0, b};
    return 64'(p >> 62);
  endfunction
  // round(65536 * 2^(-i/256)) clamped to 0xFFFF; r = 2^(-1/256) is found by bisection on r^256 = 1/2
  function automatic logic [15:0] lut_entry(input logic [7:0] i);
    logic [63:0] lo, hi, mid, sq, base, p;
    lo = 64'd1 << 61;
    hi = 64'd1 << 62;
    for (int n = 0; n < 62; n++) begin
      mid = lo + ((hi - lo) >> 1);
      sq = mid;
      for (int s = 0; s < 8; s++) sq = q62_mul(sq, sq);
      if (sq > (64'd1 << 61)) hi = mid;
      else lo = mid;
    end
    base = lo;
    p = 64'd1 << 62;
    for (int b = 0; b < 8; b++) begin
      if (i[b]) p = q62_mul(p, base);
      base = q62_mul(base, base);
    end
    p = (p + (64'd1 << 45)) >> 46;
    return (p > 64'hFFFF) ? ONE_Q16 : p[15:0];
  endfunction
endpackage

// File: rtl/exp_block_16_lut.sv
// lut_exp2_16: registered 256-entry 2^-f table, one cycle from request to data
module lut_exp2_16
  import exp_block_16_pkg::*;
#(
  parameter int lut_addr_size = 8
) (
  input  logic                     clock_i,
  input  logic                     reset_i,
  input  logic [lut_addr_size-1:0] addr_i,
  input  logic                     req_i,
  output logic [15:0]              data_o,
  output logic                     valid_o
);
  logic [15:0] rom [LUT_DEPTH];
  for (genvar i = 0; i < LUT_DEPTH; i++) begin : g_rom
    localparam logic [15:0] V = lut_entry(8'(i));
    assign rom[i] = V;
  end
  always_ff @(posedge clock_i or posedge reset_i)
    if (reset_i) begin
      data_o <= '0;
      valid_o <= 1'b0;
    end else begin
      valid_o <= req_i;
      if (req_i) data_o <= rom[addr_i];
    end
endmodule

// File: rtl/exp_block_16.sv
// exp_block_16: y = exp(x) for x <= 0 in Q4.12, computed as LUT(2^-f) >> k with a bit-serial shift
module exp_block_16
  import exp_block_16_pkg::*;
#(
  parameter int data_size = 16,
  parameter int lut_addr_size = 8
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic [data_size-1:0] exp_data_i,
  input  logic                 exp_data_valid_i,
  output logic                 exp_data_ready_o,
  output logic [data_size-1:0] exp_data_o,
  output logic                 exp_data_valid_o
);
  state_t state;
  logic [15:0] m, mant, lut_data;
  logic [3:0] k, cnt;
  logic [11:0] t_ki;
  logic lut_valid;
  // t_ki = t[15:4] of t = (m * log2(e)) >> 15: integer part k on top, table index below
  assign t_ki = 12'((32'(m) * 32'(LOG2E_Q15)) >> 19);
  assign exp_data_ready_o = state == IDLE;
  lut_exp2_16 #(.lut_addr_size(lut_addr_size)) u_lut (
    .clock_i(clock_i),
    .reset_i(reset_i),
    .addr_i(t_ki[7:0]),
    .req_i(state == MUL),
    .data_o(lut_data),
    .valid_o(lut_valid)
  );
  always_ff @(posedge clock_i or posedge reset_i)
    if (reset_i) begin
      state <= IDLE;
      m <= '0;
      mant <= '0;
      k <= '0;
      cnt <= '0;
      exp_data_o <= '0;
      exp_data_valid_o <= 1'b0;
    end else begin
      exp_data_valid_o <= 1'b0;
      case (state)
        IDLE: if (exp_data_valid_i) begin
          m <= exp_data_i[15] ? -exp_data_i : '0;
          state <= MUL;
        end
        MUL: begin
          k <= t_ki[11:8];
          state <= LUT;
        end
        LUT: if (lut_valid) begin
          mant <= lut_data;
          cnt <= k;
          state <= SHIFT;
        end
        SHIFT: if (|cnt) begin
          mant <= mant >> 1;
          cnt <= cnt - 1'b1;
        end else begin
          exp_data_o <= mant;
          exp_data_valid_o <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_exp_block_16.sv
// tb_exp_block_16: scoreboard bench for exp_block_16 against a real-arithmetic reference of the exp2 method
module tb_exp_block_16;
  logic clock_i = 1'b0;
  logic reset_i = 1'b0;
  logic [15:0] exp_data_i = '0;
  logic exp_data_valid_i = 1'b0;
  logic exp_data_ready_o;
  logic [15:0] exp_data_o;
  logic exp_data_valid_o;
  typedef struct {
    logic [15:0] y;
    int at;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  int a1, a2;
  exp_block_16 dut (
    .clock_i(clock_i),
    .reset_i(reset_i),
    .exp_data_i(exp_data_i),
    .exp_data_valid_i(exp_data_valid_i),
    .exp_data_ready_o(exp_data_ready_o),
    .exp_data_o(exp_data_o),
    .exp_data_valid_o(exp_data_valid_o)
  );
  always #5 clock_i = ~clock_i;
  always @(posedge clock_i) cyc <= cyc + 1;
  task automatic chk(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, got, got, want, want);
    end
  endtask
  // exp(x) = 2^-t, t = -x*log2(e) in Q4.12; table value rounded from 2^(-idx/256), then floor-divided by 2^k
  function automatic void model(input logic [15:0] x, output logic [15:0] y, output int k);
    int m, t, idx, l;
    real v;
    m = x[15] ? 65536 - int'(x) : 0;
    t = (m * 47274) / 32768;
    k = t / 4096;
    idx = (t % 4096) / 16;
    v = 65536.0 * $pow(2.0, -real'(idx) / 256.0);
    l = $rtoi(v + 0.5);
    if (l > 65535) l = 65535;
    y = 16'(l / (1 << k));
  endfunction
  always @(negedge clock_i)
    if (!reset_i && exp_data_valid_o) begin
      if (sb.size() == 0) chk("spurious_valid", 1, 0);
      else begin
        mon_e = sb.pop_front();
        chk("data", int'(exp_data_o), int'(mon_e.y));
        chk("latency_edge", cyc, mon_e.at);
      end
    end
  task automatic send(input logic [15:0] x, output int acc);
    logic [15:0] y;
    int k, n;
    exp_data_i = x;
    exp_data_valid_i = 1'b1;
    n = 0;
    while (!exp_data_ready_o && n < 40) begin
      @(negedge clock_i);
      n++;
    end
    if (!exp_data_ready_o) begin
      chk("accept_timeout", 0, 1);
      acc = -1;
    end else begin
      model(x, y, k);
      acc = cyc + 1;
      sb.push_back('{y, acc + 3 + k});
    end
    @(negedge clock_i);
    exp_data_valid_i = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 100) begin
      @(negedge clock_i);
      n++;
    end
    if (sb.size() > 0) begin
      chk("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask
  initial begin
    logic [15:0] x;
    int gap, mode;
    #1 reset_i = 1'b1;
    #2;
    chk("reset_data", int'(exp_data_o), 0);
    chk("reset_valid", int'(exp_data_valid_o), 0);
    chk("reset_ready", int'(exp_data_ready_o), 1);
    @(negedge clock_i);
    reset_i = 1'b0;
    @(negedge clock_i);
    send(16'h0000, a1);
    drain();
    send(16'hF000, a1);
    drain();
    send(16'h8000, a1);
    for (int i = 1; i <= 13; i++) begin
      @(negedge clock_i);
      chk("busy_ready_low", int'(exp_data_ready_o), 0);
    end
    drain();
    send(16'h1800, a1);
    drain();
    send(16'hF000, a1);
    send(16'hE000, a2);
    chk("b2b_accept_edge", a2, a1 + 5);
    drain();
    send(16'h8000, a1);
    repeat (5) @(negedge clock_i);
    #2 reset_i = 1'b1;
    #1;
    chk("async_reset_data", int'(exp_data_o), 0);
    chk("async_reset_valid", int'(exp_data_valid_o), 0);
    chk("async_reset_ready", int'(exp_data_ready_o), 1);
    sb.delete();
    @(negedge clock_i);
    reset_i = 1'b0;
    repeat (20) @(negedge clock_i);
    chk("post_reset_data", int'(exp_data_o), 0);
    send(16'h0000, a1);
    drain();
    for (int i = 0; i < 300; i++) begin
      mode = $urandom_range(0, 3);
      x = 16'($urandom);
      if (mode == 1) x[15:12] = 4'hF;
      else if (mode == 2) x[15] = 1'b1;
      gap = $urandom_range(0, 2);
      repeat (gap) @(negedge clock_i);
      send(x, a1);
    end
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
